// File: rtl/brisc_pkg.sv
// Shared types and default sizing for the brisc memory subsystem.
package brisc_pkg;

  localparam int ADDRESS_WIDTH    = 32;
  localparam int CACHE_LINE_WIDTH = 128;
  localparam int MEM_WR_CYCLES    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mem_sched_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    ICACHE = 2'd1,
    DCACHE = 2'd2
  } mem_owner_e;

endpackage

// File: rtl/mem_sched_rr_pick2.sv
// Two-way round-robin pick: on a tie, the requester that did not win last time is chosen.
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic pick_a,
  output logic pick_b
);

  assign pick_a = req_a && (!req_b || last_b);
  assign pick_b = req_b && (!req_a || !last_b);

endmodule

// File: rtl/mem_sched.sv
// Arbitrates icache/dcache line requests onto a single memory port and routes the
// read fill or write completion back to whichever cache owns the transaction.
//
// Handshake: a cache holds req and its write/addr/data stable until its grant rises;
// grant stays high for the whole transaction and drops the cycle after completion.
module mem_sched #(
  parameter int ADDRESS_WIDTH    = brisc_pkg::ADDRESS_WIDTH,
  parameter int CACHE_LINE_WIDTH = brisc_pkg::CACHE_LINE_WIDTH,
  parameter int WR_CYCLES        = brisc_pkg::MEM_WR_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        icache_req,
  input  logic                        icache_write,
  input  logic [ADDRESS_WIDTH-1:0]    icache_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] icache_data,
  input  logic                        dcache_req,
  input  logic                        dcache_write,
  input  logic [ADDRESS_WIDTH-1:0]    dcache_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] dcache_data,
  input  logic                        mem_fill_valid,
  input  logic [ADDRESS_WIDTH-1:0]    mem_fill_addr,
  output logic                        grant_icache,
  output logic                        grant_dcache,
  output logic                        fill_icache,
  output logic                        fill_dcache,
  output logic                        done_dcache,
  output logic                        mem_req,
  output logic                        mem_store,
  output logic [ADDRESS_WIDTH-1:0]    mem_addr,
  output logic [CACHE_LINE_WIDTH-1:0] mem_data
);

  import brisc_pkg::*;

  localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  mem_sched_state_e state, state_next;
  mem_owner_e       owner, last_grant;
  logic [CNT_W-1:0] cnt;
  logic             pick_i, pick_d, sel_write, fill_hit, xact_done, select;

  rr_pick2 u_pick (
    .req_a  (icache_req),
    .req_b  (dcache_req),
    .last_b (last_grant == DCACHE),
    .pick_a (pick_i),
    .pick_b (pick_d)
  );

  assign select    = (state == IDLE) && (pick_i || pick_d);
  assign sel_write = pick_d ? dcache_write : icache_write;
  // mem_addr holds the latched request address for the whole transaction.
  assign fill_hit  = mem_fill_valid && (mem_fill_addr == mem_addr);
  assign xact_done = ((state == RD_WAIT) && fill_hit) ||
                     ((state == WR_WAIT) && (cnt == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (select) state_next = sel_write ? WR_WAIT : RD_WAIT;
      RD_WAIT: if (xact_done) state_next = IDLE;
      WR_WAIT: if (xact_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_icache = (owner == ICACHE);
    grant_dcache = (owner == DCACHE);
    fill_icache  = (state == RD_WAIT) && fill_hit && (owner == ICACHE);
    fill_dcache  = (state == RD_WAIT) && fill_hit && (owner == DCACHE);
    done_dcache  = (state == WR_WAIT) && (cnt == '0) && (owner == DCACHE);
  end

  // Request latch, ownership and eviction counter; everything clears on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= NONE;
      last_grant <= ICACHE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_store  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      mem_req <= 1'b0;
      if (select) begin
        owner      <= pick_d ? DCACHE : ICACHE;
        last_grant <= pick_d ? DCACHE : ICACHE;
        mem_req    <= 1'b1;
        mem_store  <= sel_write;
        mem_addr   <= pick_d ? dcache_addr : icache_addr;
        mem_data   <= pick_d ? dcache_data : icache_data;
        cnt        <= sel_write ? CNT_W'(WR_CYCLES - 1) : '0;
      end else if (xact_done) begin
        owner     <= NONE;
        mem_store <= 1'b0;
        mem_addr  <= '0;
        mem_data  <= '0;
        cnt       <= '0;
      end else if (state == WR_WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: directed scenarios plus random traffic against a transaction-level
// reference model; memory requests are scoreboarded, per-cycle outputs checked against the model.
module tb_mem_sched;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int WRC   = 4;
  localparam int RW    = 2 + 1 + AW + DW;
  localparam int OWN_I = 1;
  localparam int OWN_D = 2;

  logic          clk, reset;
  logic          icache_req, icache_write, dcache_req, dcache_write;
  logic [AW-1:0] icache_addr, dcache_addr, fill_addr;
  logic [DW-1:0] icache_data, dcache_data;
  logic          fill_valid;
  logic          grant_icache, grant_dcache, fill_icache, fill_dcache, done_dcache;
  logic          mem_req, mem_store;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  mem_sched #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(DW), .WR_CYCLES(WRC)) dut (
    .clk(clk), .reset(reset),
    .icache_req(icache_req), .icache_write(icache_write),
    .icache_addr(icache_addr), .icache_data(icache_data),
    .dcache_req(dcache_req), .dcache_write(dcache_write),
    .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .mem_fill_valid(fill_valid), .mem_fill_addr(fill_addr),
    .grant_icache(grant_icache), .grant_dcache(grant_dcache),
    .fill_icache(fill_icache), .fill_dcache(fill_dcache), .done_dcache(done_dcache),
    .mem_req(mem_req), .mem_store(mem_store), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one transaction in flight, round-robin on ties
  bit            m_busy, m_wr, m_fresh;
  int            m_owner, m_last, m_rem, m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_fresh = 0;
    m_owner = 0; m_last = OWN_I; m_rem = 0; m_sel = 0;
    m_addr = '0; m_data = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs presented at that edge.
  task automatic model_step();
    m_fresh = 0;
    m_sel   = 0;
    if (m_busy) begin
      if (m_wr) begin
        if (m_rem == 0) begin m_busy = 0; m_owner = 0; end
        else m_rem--;
      end else if (fill_valid && fill_addr == m_addr) begin
        m_busy = 0; m_owner = 0;
      end
    end else begin
      if (icache_req && dcache_req) m_sel = (m_last == OWN_I) ? OWN_D : OWN_I;
      else if (icache_req)          m_sel = OWN_I;
      else if (dcache_req)          m_sel = OWN_D;
      if (m_sel != 0) begin
        m_busy  = 1; m_fresh = 1; m_owner = m_sel; m_last = m_sel; m_rem = WRC - 1;
        m_wr    = (m_sel == OWN_I) ? icache_write : dcache_write;
        m_addr  = (m_sel == OWN_I) ? icache_addr  : dcache_addr;
        m_data  = (m_sel == OWN_I) ? icache_data  : dcache_data;
        exp_q.push_back({2'(m_sel), m_wr, m_addr, m_data});
      end
    end
  endtask

  task automatic check_outputs();
    bit comp;
    comp = m_busy && (m_wr ? (m_rem == 0) : (fill_valid && fill_addr == m_addr));
    chk("grant_icache", 64'(grant_icache), 64'(m_busy && m_owner == OWN_I));
    chk("grant_dcache", 64'(grant_dcache), 64'(m_busy && m_owner == OWN_D));
    chk("grant_overlap", 64'(grant_icache && grant_dcache), 64'(0));
    chk("mem_req", 64'(mem_req), 64'(m_fresh));
    chk("mem_store", 64'(mem_store), 64'(m_busy && m_wr));
    chk("mem_addr", 64'(mem_addr), m_busy ? 64'(m_addr) : 64'(0));
    chk("mem_data", 64'(mem_data), m_busy ? 64'(m_data) : 64'(0));
    chk("fill_icache", 64'(fill_icache), 64'(comp && !m_wr && m_owner == OWN_I));
    chk("fill_dcache", 64'(fill_dcache), 64'(comp && !m_wr && m_owner == OWN_D));
    chk("done_dcache", 64'(done_dcache), 64'(comp && m_wr && m_owner == OWN_D));
  endtask

  // One clock: check the current cycle, let the edge happen, drop any granted request.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    if (m_sel == OWN_I) icache_req = 1'b0;
    if (m_sel == OWN_D) dcache_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic req_i(input logic wr, input logic [AW-1:0] a);
    icache_req = 1'b1; icache_write = wr; icache_addr = a; icache_data = DW'($urandom);
  endtask

  task automatic req_d(input logic wr, input logic [AW-1:0] a);
    dcache_req = 1'b1; dcache_write = wr; dcache_addr = a; dcache_data = DW'($urandom);
  endtask

  // Run the in-flight transaction and any held requests to completion, bounded.
  task automatic drain(input int limit);
    int n = 0;
    while ((m_busy || icache_req || dcache_req) && n < limit) begin
      fill_valid = m_busy && !m_wr;
      fill_addr  = m_addr;
      cycle();
      n++;
    end
    fill_valid = 1'b0;
    fill_addr  = '0;
  endtask

  task automatic random_drive();
    if (!icache_req && $urandom_range(0, 3) == 0)
      req_i($urandom_range(0, 7) == 0, AW'($urandom_range(0, 15) << 4));
    if (!dcache_req && $urandom_range(0, 3) == 0)
      req_d($urandom_range(0, 1) == 1, AW'($urandom_range(0, 15) << 4));
    if (m_busy && !m_wr && $urandom_range(0, 2) == 0) begin
      fill_valid = 1'b1;
      fill_addr  = ($urandom_range(0, 3) == 0) ? (m_addr ^ AW'(16'h0010)) : m_addr;
    end else begin
      fill_valid = ($urandom_range(0, 9) == 0);
      fill_addr  = AW'($urandom_range(0, 15) << 4);
    end
  endtask

  // monitor: every mem_req pulse must match the next expected transaction
  initial begin
    logic [RW-1:0] exp;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req_unexpected: got addr %0h with no expected request at %0t",
                   mem_addr, $time);
        end else begin
          exp = exp_q.pop_front();
          chk("mem_req_xact", 64'({grant_dcache, grant_icache, mem_store, mem_addr, mem_data}),
              64'(exp));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    icache_req = 0; icache_write = 0; icache_addr = '0; icache_data = '0;
    dcache_req = 0; dcache_write = 0; dcache_addr = '0; dcache_data = '0;
    fill_valid = 0; fill_addr = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    repeat (3) cycle();

    // icache read, fill three cycles later
    req_i(1'b0, AW'(16'h100));
    cycle();
    cycle();
    cycle();
    fill_valid = 1'b1; fill_addr = AW'(16'h100);
    cycle();
    fill_valid = 1'b0;
    cycle();
    cycle();

    // mismatching fill address is ignored
    req_i(1'b0, AW'(16'h100));
    cycle();
    fill_valid = 1'b1; fill_addr = AW'(16'h200);
    cycle();
    cycle();
    fill_addr = AW'(16'h100);
    cycle();
    fill_valid = 1'b0;
    cycle();

    // ties after reset: dcache, then icache, then dcache again
    do_reset();
    req_i(1'b0, AW'(16'h10));
    req_d(1'b0, AW'(16'h20));
    cycle();
    #1 chk("first_tie_owner", 64'({grant_dcache, grant_icache}), 64'(2'b10));
    drain(20);
    req_i(1'b0, AW'(16'h30));
    req_d(1'b0, AW'(16'h40));
    cycle();
    #1 chk("third_tie_owner", 64'({grant_dcache, grant_icache}), 64'(2'b10));
    drain(20);

    // dcache eviction write
    req_d(1'b1, AW'(16'h40));
    cycle();
    drain(20);
    cycle();

    // reset in the middle of a read, then a late fill for the old address
    req_i(1'b0, AW'(16'h300));
    cycle();
    cycle();
    do_reset();
    fill_valid = 1'b1; fill_addr = AW'(16'h300);
    cycle();
    cycle();
    fill_valid = 1'b0;
    cycle();

    // random back-to-back traffic
    for (int i = 0; i < 10000; i++) begin
      random_drive();
      cycle();
    end
    drain(200);
    repeat (2) cycle();
    chk("pending_requests", 64'(exp_q.size()), 64'(0));
    chk("final_grants", 64'({grant_dcache, grant_icache}), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 Parameter ADDRESS_WIDTH, default brisc_pkg ADDRESS_WIDTH, memory address width in bits.
REQ-002 Parameter CACHE_LINE_WIDTH, default brisc_pkg CACHE_LINE_WIDTH, line width in bits.
REQ-003 Parameter WR_CYCLES, default brisc_pkg MEM_WR_CYCLES, cycles an eviction write occupies memory (>=1).
REQ-004 Ports, in order: clk in 1, sole clock, rising edge; reset in 1, asynchronous, active-high.
REQ-005 icache_req in 1, icache_write in 1, icache_addr in ADDRESS_WIDTH, icache_data in CACHE_LINE_WIDTH: icache request, held stable until granted.
REQ-006 dcache_req in 1, dcache_write in 1, dcache_addr in ADDRESS_WIDTH, dcache_data in CACHE_LINE_WIDTH: dcache request, same holding rule.
REQ-007 mem_fill_valid in 1, mem_fill_addr in ADDRESS_WIDTH: memory read response.
REQ-008 grant_icache out 1, grant_dcache out 1: level, high while that requester owns memory.
REQ-009 fill_icache out 1, fill_dcache out 1: response routed to owner; done_dcache out 1: eviction-write complete pulse.
REQ-010 mem_req out 1, mem_store out 1, mem_addr out ADDRESS_WIDTH, mem_data out CACHE_LINE_WIDTH: registered request to memory.

Function
REQ-011 FSM states IDLE, RD_WAIT, WR_WAIT; owner register {NONE, ICACHE, DCACHE}; last_grant register.
REQ-012 In IDLE with no request, all outputs remain 0 and state remains IDLE.
REQ-013 In IDLE, if exactly one requester asserts req, it is selected on that edge.
REQ-014 If both assert req, select the one not equal to last_grant (round-robin); after reset last_grant = ICACHE, so dcache wins the first tie.
REQ-015 On selection: mem_req pulses 1 for exactly one cycle (the cycle after the edge), mem_addr/mem_data/mem_store latch the selected requester's inputs and hold until return to IDLE; grant of the selected requester rises in the same cycle as mem_req.
REQ-016 Selected read (write=0) -> RD_WAIT; selected write -> WR_WAIT with counter loaded to WR_CYCLES-1.
REQ-017 RD_WAIT: on mem_fill_valid with mem_fill_addr == latched mem_addr, the owner's fill_* output pulses 1 combinationally that cycle; next state IDLE, grant drops next cycle.
REQ-018 RD_WAIT: mem_fill_valid with mismatching address is ignored (no fill pulse, no state change).
REQ-019 WR_WAIT: counter decrements each cycle; at 0, done_dcache (or icache equivalent, unused) pulses 1 cycle; next state IDLE.
REQ-020 Minimum latency: request seen at edge N -> mem_req high in cycle N+1; earliest re-arbitration at the edge after completion.
REQ-021 Requests arriving while not IDLE are not acknowledged; they are arbitrated at the IDLE edge after completion.
REQ-022 Requester deasserting req while owner is ignored; transaction runs to completion.
REQ-023 grant_icache and grant_dcache are never both 1; fill outputs only assert for the current owner.
REQ-024 last_grant updates on each selection.

Reset
REQ-025 reset asserted asynchronously forces state IDLE, owner NONE, last_grant ICACHE, counter 0, all outputs 0, including mid-transaction; an in-flight fill after release is ignored.

Structure
REQ-026 brisc_pkg holds mem_sched_state_e, mem_owner_e and MEM_WR_CYCLES; no local typedefs.
REQ-027 One sub-module, rr_pick2 (two-way round-robin select on last_grant), is natural; counter and FSM stay in mem_sched.

Verification
REQ-028 icache_req read addr 0x100, fill 3 cycles later with addr 0x100 -> mem_req 1 cycle, grant_icache held, fill_icache 1 pulse, IDLE.
REQ-029 Both req same edge after reset -> dcache granted first; after completion icache granted; third tie -> dcache.
REQ-030 dcache write, WR_CYCLES=4 -> mem_store=1, grant_dcache 4 cycles, done_dcache pulse on 4th, then IDLE.
REQ-031 RD_WAIT, fill addr 0x200 vs latched 0x100 -> no fill pulse; later 0x100 -> fill_icache pulse.
REQ-032 reset asserted in RD_WAIT -> outputs 0 immediately; subsequent fill for old addr -> no fill pulse.
REQ-033 Random back-to-back requests 10k cycles -> grants never overlap, every request eventually completes.
